counter_updown_mod: RTL and testbench

Parametrised up/down counter with enable, synchronous clear and load, a programmable modulus, and a choice of wrap or saturate mode. It replaces the fixed 4-bit free-running counter as the general-purpose counting primitive for timers, dividers and event counters. It provides terminal/zero flags, a one-cycle wrap pulse, and a sticky overflow indication for status registers.

---
 rtl/counter_updown_mod_if.sv | 27 ++
 rtl/counter_updown_mod.sv | 77 +++++++
 tb/tb_counter_updown_mod.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_max;
    logic             at_zero;
    logic             ovf_sticky;

    // Controller side: drives commands, observes status.
    modport master (
        output en, up, clr, load, load_val,
        input  count, wrap, at_max, at_zero, ovf_sticky
    );

    // Counter side: consumes commands, produces status.
    modport slave (
        input  en, up, clr, load, load_val,
        output count, wrap, at_max, at_zero, ovf_sticky
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter: enable, sync clear/load, programmable
// terminal count, wrap or saturate at limits, wrap pulse and sticky overflow.
module counter_updown_mod #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_updown_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_ovf_nxt;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_count == MAX_C);
    assign w_at_zero = (r_count == '0);

    // Next state: clr > load > en > hold; limits compared before stepping so
    // no intermediate value ever leaves the WIDTH-bit range.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (bus.clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (bus.load) begin
            w_count_nxt = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_max) begin
                    w_wrap_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = SATURATE ? MAX_C : '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_wrap_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = SATURATE ? '0 : MAX_C;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.count      = r_count;
    assign bus.wrap       = r_wrap;
    assign bus.ovf_sticky = r_ovf;
    assign bus.at_max     = w_at_max;
    assign bus.at_zero    = w_at_zero;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench for counter_updown_mod: wrap, saturate,
// full-range and MAX_VAL=1 configurations.
module tb_counter_updown_mod;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    counter_updown_mod_if #(.WIDTH(4)) ifa ();
    counter_updown_mod_if #(.WIDTH(4)) ifs ();
    counter_updown_mod_if #(.WIDTH(8)) iff_ ();
    counter_updown_mod_if #(.WIDTH(2)) ifm ();

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1'b0)) ua (.clk(clk), .rst(rst), .bus(ifa));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1'b1)) us (.clk(clk), .rst(rst), .bus(ifs));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) uf (.clk(clk), .rst(rst), .bus(iff_));
    counter_updown_mod #(.WIDTH(2), .MAX_VAL(1),   .SATURATE(1'b0)) um (.clk(clk), .rst(rst), .bus(ifm));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] cnt;
        logic       wrap;
        logic       ovf;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t v(input logic c, input logic l, input logic e, input logic u,
                               input logic [3:0] lv, input logic [3:0] cnt,
                               input logic w, input logic o);
        vec_t t;
        t = '{clr: c, load: l, en: e, up: u, lv: lv, cnt: cnt, wrap: w, ovf: o};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check all status of the wrap-mode W=4/MAX=9 instance.
    task automatic chk_a(input string tag, input logic [3:0] cnt, input logic w, input logic o);
        chk({tag, ".count"},   32'(ifa.count), 32'(cnt));
        chk({tag, ".wrap"},    32'(ifa.wrap), 32'(w));
        chk({tag, ".ovf"},     32'(ifa.ovf_sticky), 32'(o));
        chk({tag, ".at_max"},  32'(ifa.at_max), 32'(cnt == 4'd9));
        chk({tag, ".at_zero"}, 32'(ifa.at_zero), 32'(cnt == 4'd0));
    endtask

    task automatic chk_s(input string tag, input logic [3:0] cnt, input logic w, input logic o);
        chk({tag, ".count"},   32'(ifs.count), 32'(cnt));
        chk({tag, ".wrap"},    32'(ifs.wrap), 32'(w));
        chk({tag, ".ovf"},     32'(ifs.ovf_sticky), 32'(o));
        chk({tag, ".at_max"},  32'(ifs.at_max), 32'(cnt == 4'd9));
        chk({tag, ".at_zero"}, 32'(ifs.at_zero), 32'(cnt == 4'd0));
    endtask

    task automatic chk_f(input string tag, input logic [7:0] cnt, input logic w, input logic o);
        chk({tag, ".count"},   32'(iff_.count), 32'(cnt));
        chk({tag, ".wrap"},    32'(iff_.wrap), 32'(w));
        chk({tag, ".ovf"},     32'(iff_.ovf_sticky), 32'(o));
        chk({tag, ".at_max"},  32'(iff_.at_max), 32'(cnt == 8'd255));
        chk({tag, ".at_zero"}, 32'(iff_.at_zero), 32'(cnt == 8'd0));
    endtask

    task automatic chk_m(input string tag, input logic [1:0] cnt, input logic w, input logic o);
        chk({tag, ".count"}, 32'(ifm.count), 32'(cnt));
        chk({tag, ".wrap"},  32'(ifm.wrap), 32'(w));
        chk({tag, ".ovf"},   32'(ifm.ovf_sticky), 32'(o));
        chk({tag, ".at_max"}, 32'(ifm.at_max), 32'(cnt == 2'd1));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //           clr  load en  up   lv     cnt    wrap ovf
        vecs[0]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd1, 1'b0,1'b0);
        vecs[1]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd2, 1'b0,1'b0);
        vecs[2]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd3, 1'b0,1'b0);
        vecs[3]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd4, 1'b0,1'b0);
        vecs[4]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd5, 1'b0,1'b0);
        vecs[5]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd6, 1'b0,1'b0);
        vecs[6]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd7, 1'b0,1'b0);
        vecs[7]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd8, 1'b0,1'b0);
        vecs[8]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd9, 1'b0,1'b0);
        vecs[9]  = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd0, 1'b1,1'b1);
        vecs[10] = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd1, 1'b0,1'b1);
        vecs[11] = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd2, 1'b0,1'b1);
        vecs[12] = v(1'b0,1'b0,1'b1,1'b0,4'd0, 4'd1, 1'b0,1'b1);
        vecs[13] = v(1'b0,1'b0,1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b1);
        vecs[14] = v(1'b0,1'b0,1'b1,1'b0,4'd0, 4'd9, 1'b1,1'b1);
        vecs[15] = v(1'b0,1'b0,1'b1,1'b0,4'd0, 4'd8, 1'b0,1'b1);
        vecs[16] = v(1'b0,1'b0,1'b0,1'b1,4'd0, 4'd8, 1'b0,1'b1);
        vecs[17] = v(1'b1,1'b1,1'b1,1'b1,4'd5, 4'd0, 1'b0,1'b0);
        vecs[18] = v(1'b0,1'b1,1'b1,1'b1,4'd7, 4'd7, 1'b0,1'b0);
        vecs[19] = v(1'b0,1'b1,1'b0,1'b1,4'd14,4'd9, 1'b0,1'b0);
        vecs[20] = v(1'b0,1'b0,1'b1,1'b1,4'd0, 4'd0, 1'b1,1'b1);
        vecs[21] = v(1'b0,1'b1,1'b1,1'b1,4'd3, 4'd3, 1'b0,1'b1);
        vecs[22] = v(1'b1,1'b0,1'b0,1'b1,4'd0, 4'd0, 1'b0,1'b0);

        rst = 1'b1;
        {ifa.en, ifa.up, ifa.clr, ifa.load} = 4'b0;   ifa.load_val  = '0;
        {ifs.en, ifs.up, ifs.clr, ifs.load} = 4'b0;   ifs.load_val  = '0;
        {iff_.en, iff_.up, iff_.clr, iff_.load} = 4'b0; iff_.load_val = '0;
        {ifm.en, ifm.up, ifm.clr, ifm.load} = 4'b0;   ifm.load_val  = '0;

        // Reset values while rst held high, then release mid-cycle at 20 ns.
        @(posedge clk);
        #2;
        chk_a("rst0", 4'd0, 1'b0, 1'b0);
        #13;
        chk_a("rst1", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table: wrap up, wrap down, hold, priority, load and clamp.
        for (int i = 0; i < NV; i++) begin
            ifa.clr = vecs[i].clr;
            ifa.load = vecs[i].load;
            ifa.en = vecs[i].en;
            ifa.up = vecs[i].up;
            ifa.load_val = vecs[i].lv;
            step();
            chk_a($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wrap, vecs[i].ovf);
        end
        {ifa.clr, ifa.load} = 2'b00;

        // Asynchronous reset mid-count, then resume counting.
        ifa.en = 1'b1;
        ifa.up = 1'b1;
        repeat (16) step();
        chk_a("pre_rst", 4'd6, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk_a("async_rst", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        chk_a("resume1", 4'd1, 1'b0, 1'b0);
        step();
        chk_a("resume2", 4'd2, 1'b0, 1'b0);
        ifa.en = 1'b0;

        // Saturate mode: hold at 9 with pulses, then down to 0 and hold.
        ifs.en = 1'b1;
        ifs.up = 1'b1;
        repeat (9) step();
        chk_s("sat_up9", 4'd9, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_s($sformatf("sat_hi%0d", k), 4'd9, 1'b1, 1'b1);
        end
        ifs.en = 1'b0;
        step();
        chk_s("sat_idle", 4'd9, 1'b0, 1'b1);
        ifs.en = 1'b1;
        ifs.up = 1'b0;
        step();
        chk_s("sat_dn8", 4'd8, 1'b0, 1'b1);
        repeat (8) step();
        chk_s("sat_dn0", 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_s($sformatf("sat_lo%0d", k), 4'd0, 1'b1, 1'b1);
        end
        ifs.en = 1'b0;

        // Full 8-bit range: all-ones wraps to zero.
        iff_.load = 1'b1;
        iff_.load_val = 8'd254;
        step();
        chk_f("full_ld", 8'd254, 1'b0, 1'b0);
        iff_.load = 1'b0;
        iff_.en = 1'b1;
        iff_.up = 1'b1;
        step();
        chk_f("full_255", 8'd255, 1'b0, 1'b0);
        step();
        chk_f("full_0", 8'd0, 1'b1, 1'b1);
        step();
        chk_f("full_1", 8'd1, 1'b0, 1'b1);
        iff_.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_f($sformatf("full_hold%0d", k), 8'd1, 1'b0, 1'b1);
            chk($sformatf("full_nox%0d", k), 32'($isunknown(iff_.count)), 32'd0);
        end

        // MAX_VAL=1: toggles, every enabled edge at a limit is an event.
        ifm.en = 1'b1;
        ifm.up = 1'b1;
        step();
        chk_m("m1_up1", 2'd1, 1'b0, 1'b0);
        step();
        chk_m("m1_up0", 2'd0, 1'b1, 1'b1);
        ifm.up = 1'b0;
        step();
        chk_m("m1_dn1", 2'd1, 1'b1, 1'b1);
        step();
        chk_m("m1_dn0", 2'd0, 1'b0, 1'b1);
        ifm.up = 1'b1;
        step();
        chk_m("m1_up1b", 2'd1, 1'b0, 1'b1);
        ifm.en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
